// File: rtl/m_moving_avg.sv
// Sliding-window averager: DEPTH-deep sample window with an incrementally
// updated running sum, registered sum/DEPTH output (truncated or rounded).
module m_moving_avg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int ROUND = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               out_avg,
  output logic [WIDTH+$clog2(DEPTH)-1:0] out_sum,
  output logic [$clog2(DEPTH):0]         fill,
  output logic                           primed
);

  localparam int LOG2D = $clog2(DEPTH);
  localparam int SUM_W = WIDTH + LOG2D;
  localparam logic [LOG2D:0] FILL_MAX = (LOG2D+1)'(DEPTH);
  localparam logic [SUM_W:0] RND_ADD  = (ROUND != 0) ? (SUM_W+1)'(DEPTH / 2) : '0;

  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] slot [DEPTH];
  logic             accept;
  logic [SUM_W-1:0] sum_next;
  logic [SUM_W:0]   rounded;
  logic             unused_bits;

  assign accept = in_valid & ~clr;
  assign primed = (state == S_RUN);

  // Subtracting the oldest slot before the shift keeps the sum exact;
  // the sum always contains that slot, so the difference never goes negative.
  assign sum_next = out_sum + {{LOG2D{1'b0}}, in_data}
                            - {{LOG2D{1'b0}}, slot[DEPTH-1]};
  assign rounded  = {1'b0, sum_next} + RND_ADD;
  assign unused_bits = ^{rounded[SUM_W], rounded[LOG2D-1:0]};

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    if (clr)
      state_next = S_FILL;
    else if (accept && state == S_FILL && fill == FILL_MAX - 1'b1)
      state_next = S_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FILL;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the window is reset because the running sum assumes empty slots hold 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
      out_sum   <= '0;
      out_avg   <= '0;
      out_valid <= 1'b0;
      fill      <= '0;
    end else begin
      // NOTE: non-blocking assignments let every slot shift from its pre-edge neighbour.
      out_valid <= accept;
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
        out_sum <= '0;
        out_avg <= '0;
        fill    <= '0;
      end else if (accept) begin
        slot[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) slot[i] <= slot[i-1];
        out_sum <= sum_next;
        out_avg <= rounded[LOG2D +: WIDTH];
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_m_moving_avg.sv
// Bench for m_moving_avg: truncating and rounding instances driven in lockstep,
// compared each cycle against a queue-based window model.
module tb_m_moving_avg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LOG2D = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;

  logic             valid_t, valid_r;
  logic [WIDTH-1:0] avg_t, avg_r;
  logic [WIDTH+LOG2D-1:0] sum_t, sum_r;
  logic [LOG2D:0]   fill_t, fill_r;
  logic             primed_t, primed_r;

  m_moving_avg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ROUND(0)) dut_trunc (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(valid_t), .out_avg(avg_t), .out_sum(sum_t), .fill(fill_t), .primed(primed_t)
  );

  m_moving_avg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ROUND(1)) dut_round (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(valid_r), .out_avg(avg_r), .out_sum(sum_r), .fill(fill_r), .primed(primed_r)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int unsigned win[$];
  int unsigned m_sum, m_avg_t, m_avg_r;
  bit          m_valid;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    win.delete();
    m_sum = 0; m_avg_t = 0; m_avg_r = 0; m_valid = 0;
  endfunction

  function automatic void model_step(bit v, int unsigned d, bit c);
    if (c) begin
      model_reset();
    end else if (v) begin
      win.push_front(d);
      if (win.size() > DEPTH) void'(win.pop_back());
      m_sum = 0;
      foreach (win[i]) m_sum += win[i];
      m_avg_t = m_sum / DEPTH;
      m_avg_r = (m_sum + DEPTH / 2) / DEPTH;
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
  endfunction

  task automatic check_all(input string tag);
    int unsigned f;
    f = win.size();
    check({tag, "_valid_t"},  valid_t,  m_valid);
    check({tag, "_valid_r"},  valid_r,  m_valid);
    check({tag, "_sum_t"},    sum_t,    m_sum);
    check({tag, "_sum_r"},    sum_r,    m_sum);
    check({tag, "_avg_t"},    avg_t,    m_avg_t);
    check({tag, "_avg_r"},    avg_r,    m_avg_r);
    check({tag, "_fill_t"},   fill_t,   f);
    check({tag, "_fill_r"},   fill_r,   f);
    check({tag, "_primed_t"}, primed_t, (f == DEPTH) ? 1 : 0);
    check({tag, "_primed_r"}, primed_r, (f == DEPTH) ? 1 : 0);
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, sample 1ns later.
  task automatic step(input string tag, input bit v, input int unsigned d, input bit c = 1'b0);
    in_valid = v;
    in_data  = d[WIDTH-1:0];
    clr      = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    int unsigned fill_seq [4] = '{4, 8, 12, 16};
    int unsigned avg_seq  [4] = '{1, 3, 6, 10};

    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill
    for (int i = 0; i < 4; i++) begin
      step("fill", 1'b1, fill_seq[i]);
      check("fill_avg_const", avg_t, avg_seq[i]);
      check("fill_cnt_const", fill_t, i + 1);
    end
    check("fill_sum_const", sum_t, 40);
    check("fill_primed_const", primed_t, 1);

    // Slide with idle gaps
    step("slide", 1'b1, 20);
    check("slide_sum_const", sum_t, 56);
    check("slide_avg_const", avg_t, 14);
    for (int i = 0; i < 3; i++) begin
      step("idle", 1'b0, 77);
      check("idle_hold_avg", avg_t, 14);
    end
    step("slide2", 1'b1, 24);
    check("slide2_sum_const", sum_t, 72);
    check("slide2_avg_const", avg_t, 18);

    // Saturation
    for (int i = 0; i < 6; i++) step("sat", 1'b1, 255);
    check("sat_sum_const", sum_t, 1020);
    check("sat_avg_t_const", avg_t, 255);
    check("sat_avg_r_const", avg_r, 255);
    check("sat_fill_const", fill_t, 4);

    // Clear wins over a same-cycle sample
    step("clr", 1'b1, 99, 1'b1);
    check("clr_sum_const", sum_t, 0);
    check("clr_fill_const", fill_t, 0);
    check("clr_valid_const", valid_t, 0);

    // Rounding: sum 1 then 2
    step("rnd1", 1'b1, 1);
    check("rnd1_avg_r", avg_r, 0);
    check("rnd1_avg_t", avg_t, 0);
    step("rnd2", 1'b1, 1);
    check("rnd2_avg_r", avg_r, 1);
    check("rnd2_avg_t", avg_t, 0);

    // Async reset between clock edges
    step("pre_rst", 1'b1, 200);
    step("pre_rst", 1'b1, 100);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 8);
    check("post_rst_avg_const", avg_t, 2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit v, c;
      int unsigned d;
      v = ($urandom_range(9) < 7);
      c = ($urandom_range(39) == 0);
      d = ($urandom_range(7) == 0) ? 255 : $urandom_range(255);
      step("rand", v, d, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
